// File: rtl/rv_sync_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_sync_fifo_pkg
// Description : Shared types, widths and elaboration helpers for the
//               ready/valid synchronous FIFO slice.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_sync_fifo_pkg;

    // Default payload width for ready/valid links in this codebase.
    localparam int ARCH_WIDTH = 32;

    // True when v is a positive power of two.
    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    // Larger of two integers, usable in constant expressions.
    function automatic int MAX(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv_sync_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : rv_if
// Description : Ready/valid handshake link. RX is the accepting side,
//               TX is the producing side.
// Revision    : 1.0 - initial release
// ============================================================================
interface rv_if
    import rv_sync_fifo_pkg::*;
#(
    parameter int DW = ARCH_WIDTH
);
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;

    modport RX (input valid, input data, output ready);
    modport TX (output valid, output data, input ready);
endinterface
`default_nettype wire

// File: rtl/rv_sync_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : rv_fifo_mem
// Description : DEPTH x DW storage, one synchronous write port and one
//               asynchronous read port. Contents are never reset.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_fifo_mem #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  wire logic                     clk,
    input  wire logic                     i_we,
    input  wire logic [$clog2(DEPTH)-1:0] i_waddr,
    input  wire logic [DW-1:0]            i_wdata,
    input  wire logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic      [DW-1:0]            o_rdata
);
    logic [DW-1:0] r_mem [DEPTH];

    // Write the addressed entry when enabled; no reset so flush/reset leave data.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule
`default_nettype wire

// File: rtl/rv_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rv_sync_fifo
// Description : Single-clock ready/valid FIFO with occupancy flags, flush,
//               and an optional zero-latency bypass when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_sync_fifo
    import rv_sync_fifo_pkg::*;
#(
    parameter int   DW        = ARCH_WIDTH,
    parameter int   DEPTH     = 4,
    parameter int   AF_THRESH = DEPTH - 1,
    parameter logic BYPASS    = 1'b0
) (
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    input  wire logic                       flush,
    rv_if.RX                                in,
    rv_if.TX                                out,
    output logic [$clog2(DEPTH+1)-1:0]      count,
    output logic                            full,
    output logic                            empty,
    output logic                            almost_full
);
    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = $clog2(DEPTH + 1);
    localparam logic [c_cw-1:0] c_depth = c_cw'(DEPTH);
    localparam logic [c_cw-1:0] c_af    = c_cw'(AF_THRESH);
    localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);
    localparam logic [c_cw-1:0] c_cnt_one = c_cw'(1);

    // Elaboration-time parameter sanity checks.
    if (!is_pow2(DEPTH)) begin : g_chk_pow2
        $error("rv_sync_fifo: DEPTH must be a power of two");
    end
    if (MAX(DEPTH, 2) != DEPTH) begin : g_chk_min_depth
        $error("rv_sync_fifo: DEPTH must be at least 2");
    end
    if (MAX(AF_THRESH, DEPTH) != DEPTH) begin : g_chk_af
        $error("rv_sync_fifo: AF_THRESH must not exceed DEPTH");
    end

    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_cw-1:0] r_count;

    logic            w_full;
    logic            w_empty;
    logic            w_in_ready;
    logic            w_out_valid;
    logic            w_bypass_act;
    logic            w_push;
    logic            w_pop;
    logic            w_bypass_xfer;
    logic            w_wr_en;
    logic            w_rd_en;
    logic [DW-1:0]   w_rd_data;

    // Flags come straight from the registered count.
    assign w_full      = (r_count == c_depth);
    assign w_empty     = (r_count == '0);
    assign full        = w_full;
    assign empty       = w_empty;
    assign almost_full = (r_count >= c_af);
    assign count       = r_count;

    // Handshake: a full FIFO never accepts, even if it pops this cycle.
    assign w_in_ready   = !w_full && !flush && rst_n;
    assign w_bypass_act = BYPASS && w_empty;
    assign w_out_valid  = rst_n && !flush && (w_bypass_act ? in.valid : !w_empty);

    assign in.ready  = w_in_ready;
    assign out.valid = w_out_valid;
    assign out.data  = w_bypass_act ? in.data : w_rd_data;

    assign w_push = in.valid && w_in_ready;
    assign w_pop  = w_out_valid && out.ready;

    // A word that flows straight through on the bypass path touches no state.
    assign w_bypass_xfer = w_bypass_act && w_push && out.ready;
    assign w_wr_en       = w_push && !w_bypass_xfer;
    assign w_rd_en       = w_pop && !w_bypass_xfer;

    // Pointer and occupancy update; flush wins over any transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    rv_fifo_mem #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_en),
        .i_waddr (r_wr_ptr),
        .i_wdata (in.data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );
endmodule
`default_nettype wire

// File: tb/tb_rv_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_sync_fifo
// Description : Self-checking bench for rv_sync_fifo. Drives one plain and
//               one bypass instance with identical stimulus and compares both
//               against queue-based reference models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_sync_fifo;
    localparam int DEPTH = 4;
    localparam int AF    = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v_s;
    logic [31:0] d_s;
    logic        r_s;
    logic        flush_s;

    int checks   = 0;
    int failures = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];

    logic [2:0] c0, c1;
    logic f0, e0, af0, f1, e1, af1;

    always #5 clk = ~clk;

    rv_if #(.DW(32)) in0 ();
    rv_if #(.DW(32)) out0 ();
    rv_if #(.DW(32)) in1 ();
    rv_if #(.DW(32)) out1 ();

    assign in0.valid  = v_s;
    assign in0.data   = d_s;
    assign out0.ready = r_s;
    assign in1.valid  = v_s;
    assign in1.data   = d_s;
    assign out1.ready = r_s;

    rv_sync_fifo #(.DW(32), .DEPTH(DEPTH), .AF_THRESH(AF), .BYPASS(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush_s), .in(in0), .out(out0),
        .count(c0), .full(f0), .empty(e0), .almost_full(af0)
    );

    rv_sync_fifo #(.DW(32), .DEPTH(DEPTH), .AF_THRESH(AF), .BYPASS(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush_s), .in(in1), .out(out1),
        .count(c1), .full(f1), .empty(e1), .almost_full(af1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected outputs of one FIFO from its occupancy, head word and inputs.
    task automatic check_one(input string pfx, input int sz, input logic [31:0] head,
                             input bit byp, input logic [2:0] cnt, input logic f,
                             input logic e, input logic af, input logic ir,
                             input logic ov, input logic [31:0] od);
        bit bact;
        bit ev;
        bact = byp && (sz == 0);
        ev   = rst_n && !flush_s && (bact ? v_s : (sz > 0));
        check_eq({pfx, ".count"}, {29'd0, cnt}, sz);
        check_eq({pfx, ".full"}, f, sz == DEPTH);
        check_eq({pfx, ".empty"}, e, sz == 0);
        check_eq({pfx, ".afull"}, af, sz >= AF);
        check_eq({pfx, ".in_ready"}, ir, rst_n && !flush_s && (sz < DEPTH));
        check_eq({pfx, ".out_valid"}, ov, ev);
        if (ev) begin
            check_eq({pfx, ".out_data"}, od, bact ? d_s : head);
        end
    endtask

    task automatic check_all();
        logic [31:0] h0, h1;
        h0 = (q0.size() > 0) ? q0[0] : 32'd0;
        h1 = (q1.size() > 0) ? q1[0] : 32'd0;
        check_one("b0", q0.size(), h0, 1'b0, c0, f0, e0, af0, in0.ready, out0.valid, out0.data);
        check_one("b1", q1.size(), h1, 1'b1, c1, f1, e1, af1, in1.ready, out1.valid, out1.data);
    endtask

    // Returns {pop, push} to apply to the model queue at the coming edge.
    function automatic logic [1:0] model_ops(input int sz, input bit byp);
        bit rdy, bact, ov, push, pop;
        rdy  = rst_n && !flush_s && (sz < DEPTH);
        bact = byp && (sz == 0);
        ov   = rst_n && !flush_s && (bact ? v_s : (sz > 0));
        push = v_s && rdy;
        pop  = ov && r_s;
        if (bact && push && r_s) return 2'b00;
        return {pop, push};
    endfunction

    task automatic step(input bit v, input logic [31:0] d, input bit r, input bit f);
        logic [1:0] ops0, ops1;
        v_s = v; d_s = d; r_s = r; flush_s = f;
        @(negedge clk);
        check_all();
        ops0 = model_ops(q0.size(), 1'b0);
        ops1 = model_ops(q1.size(), 1'b1);
        @(posedge clk);
        if (!rst_n || flush_s) begin
            q0.delete();
            q1.delete();
        end else begin
            if (ops0[1]) void'(q0.pop_front());
            if (ops0[0]) q0.push_back(d_s);
            if (ops1[1]) void'(q1.pop_front());
            if (ops1[0]) q1.push_back(d_s);
        end
        #1;
    endtask

    initial begin
        v_s = 1'b0; d_s = '0; r_s = 1'b0; flush_s = 1'b0; rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Fill, then push against a full FIFO while popping, then drain.
        for (int i = 0; i < 4; i++) step(1'b1, 32'hA0 + i, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        check_eq("fill.count", {29'd0, c0}, 4);
        check_eq("fill.full", f0, 1'b1);
        step(1'b1, 32'hBB, 1'b1, 1'b0);
        check_eq("fullpush.count", {29'd0, c0}, 3);
        repeat (4) step(1'b0, 32'd0, 1'b1, 1'b0);
        check_eq("drain.empty", e0, 1'b1);

        // Wrap-around.
        for (int i = 0; i < 3; i++) step(1'b1, 32'hC0 + i, 1'b0, 1'b0);
        repeat (2) step(1'b0, 32'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 32'hC3 + i, 1'b0, 1'b0);
        check_eq("wrap.count", {29'd0, c0}, 4);
        repeat (4) step(1'b0, 32'd0, 1'b1, 1'b0);

        // Simultaneous push/pop at count 2.
        step(1'b1, 32'hD0, 1'b0, 1'b0);
        step(1'b1, 32'hD1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 32'hD2 + i, 1'b1, 1'b0);
        check_eq("pushpop.count", {29'd0, c0}, 2);
        repeat (2) step(1'b0, 32'd0, 1'b1, 1'b0);

        // Bypass path on an empty FIFO.
        step(1'b1, 32'h55, 1'b1, 1'b0);
        check_eq("bypass.count0", {29'd0, c1}, 0);
        step(1'b1, 32'h55, 1'b0, 1'b0);
        check_eq("bypass.count1", {29'd0, c1}, 1);
        repeat (2) step(1'b0, 32'd0, 1'b1, 1'b0);

        // Flush together with a push at count 3.
        for (int i = 0; i < 3; i++) step(1'b1, 32'hE0 + i, 1'b0, 1'b0);
        step(1'b1, 32'hEE, 1'b0, 1'b1);
        check_eq("flush.count", {29'd0, c0}, 0);
        check_eq("flush.empty", e0, 1'b1);
        step(1'b0, 32'd0, 1'b1, 1'b0);

        // Randomized traffic with occasional flush.
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 31) == 0);
        end

        // Asynchronous reset mid-cycle with entries present.
        step(1'b1, 32'h11, 1'b0, 1'b0);
        step(1'b1, 32'h22, 1'b1, 1'b0);
        v_s = 1'b1; d_s = 32'h33; r_s = 1'b1; flush_s = 1'b0;
        #2 rst_n = 1'b0;
        q0.delete();
        q1.delete();
        #1;
        check_all();
        check_eq("arst.count", {29'd0, c0}, 0);
        check_eq("arst.out_valid_b1", out1.valid, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b1, 32'h77, 1'b0, 1'b0);
        check_eq("postrst.count", {29'd0, c0}, 1);
        step(1'b0, 32'd0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/rv_sync_fifo.md
RV_SYNC_FIFO -- requirements
Module: rv_sync_fifo

Interface
REQ-001 Parameter DW, default ARCH_WIDTH, payload width in bits.
REQ-002 Parameter DEPTH, default 4, number of entries; must be a power of two.
REQ-003 Parameter AF_THRESH, default DEPTH-1, occupancy at or above which almost_full asserts.
REQ-004 Parameter BYPASS, default 1'b0, enables the zero-latency empty-FIFO path when 1.
REQ-005 clk  input  1  single clock, rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 flush  input  1  synchronous clear of all entries.
REQ-008 in  rv_if.RX  DW  producer side: valid, data in; ready out.
REQ-009 out  rv_if.TX  DW  consumer side: valid, data out; ready in.
REQ-010 count  output  $clog2(DEPTH+1)  current occupancy.
REQ-011 full  output  1  count == DEPTH.
REQ-012 empty  output  1  count == 0.
REQ-013 almost_full  output  1  count >= AF_THRESH.

Function
REQ-014 Push = in.valid && in.ready; pop = out.valid && out.ready; both are evaluated in the same cycle.
REQ-015 in.ready = !full && !flush && rst_n; a full FIFO accepts no push, even if a pop occurs in the same cycle.
REQ-016 With BYPASS=0, out.valid = !empty and out.data = the entry at the read pointer; push-to-out.valid latency is 1 cycle.
REQ-017 With BYPASS=1 and empty=1: out.valid = in.valid and out.data = in.data combinationally.
REQ-018 Under REQ-017, if out.ready=1, the word is consumed and not written, and count stays 0.
REQ-019 Under REQ-017, if out.ready=0, the word is written normally.
REQ-020 Write and read pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-021 count is updated each cycle as +1 on push only, -1 on pop only, and unchanged on push+pop or on a bypassed transfer.
REQ-022 On simultaneous push and pop with 0 < count < DEPTH: count is unchanged, both pointers advance, and FIFO order is preserved.
REQ-023 A pop on empty cannot occur, since out.valid=0 (except on the bypass path).
REQ-024 When flush=1, on the next edge pointers and count go to 0; any push or pop in that cycle is ignored.
REQ-025 flush has priority over push and pop.
REQ-026 While flush=1, out.valid is forced to 0.
REQ-027 Storage contents are not cleared by flush or reset; only pointers and count are.
REQ-028 full, empty and almost_full are derived combinationally from the registered count; no additional latency.
REQ-029 out.data is held stable while out.valid=1 && out.ready=0 (rv_if stability rule).

Reset
REQ-030 While rst_n=0, asynchronously: pointers=0, count=0, empty=1, full=0, almost_full=(AF_THRESH==0), out.valid=0, in.ready=0.
REQ-031 Reset asserted mid-transfer discards all entries; no partial push or pop is committed.
REQ-032 The first push is accepted on the first rising edge with rst_n=1.

Structure
REQ-033 The build-time checks use is_pow2 and MAX from the shared types package.
REQ-034 Build fails if DEPTH is not a power of two, DEPTH < 2, or AF_THRESH > DEPTH.
REQ-035 No new shared typedefs are required; the rv_if interface is reused unchanged from the shared package.
REQ-036 The storage array is a sub-module rv_fifo_mem (DEPTH x DW, one write port, async read); pointer and count logic lives in rv_sync_fifo.

Verification
(All scenarios use DW=32, DEPTH=4, AF_THRESH=3 unless stated.)
REQ-037 Fill/drain, BYPASS=0: push 0xA0..0xA3 with out.ready=0 -> count 1,2,3,4; almost_full at count 3; full=1 and in.ready=0 at count 4; then drain -> 0xA0..0xA3 in order, empty=1 after the 4th pop.
REQ-038 Wrap-around: 3 pushes, 2 pops, then 3 pushes -> write pointer wraps through 3->0; outputs are in push order; count ends at 4.
REQ-039 Simultaneous push/pop at count=2 for 10 cycles -> count stays 2; data out equals data in delayed by 2 transfers.
REQ-040 Push attempted while full with out.ready=1 -> in.ready=0, so the word is not accepted; count goes 4->3.
REQ-041 BYPASS=1: with empty=1, in.valid=1, data=0x55, out.ready=1 -> out.valid=1 and out.data=0x55 in the same cycle, count stays 0; repeat with out.ready=0 -> count becomes 1.
REQ-042 Flush and reset: at count=3, assert flush together with a push -> next cycle count=0, empty=1, pushed word lost; separately, drop rst_n mid-cycle -> outputs reach reset values before the next edge.
